ark_stream_out: RTL and testbench

Downstream neighbour of the round FSM (SubBytes -> ShiftRows -> MixColumns).
- Captures the DIM x DIM mixed-state matrix on the rising edge of the FSM's done flag.
- XORs it with a round key (AddRoundKey).
- Presents the full result in parallel and streams it byte-serially through a valid/ready handshake, so the round output reaches the byte-wide output path.

---
 rtl/ark_pkg.sv | 22 ++
 rtl/add_round_key.sv | 21 ++
 rtl/ark_stream_out.sv | 131 +++++++++++++
 tb/tb_ark_stream_out.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ark_pkg.sv
// Types and helpers shared by the AddRoundKey output stage and the round FSM packing.
package ark_pkg;

  localparam int unsigned ARK_WIDTH = 8;
  localparam int unsigned ARK_DIM   = 4;

  typedef logic [ARK_WIDTH-1:0] matrix_t [ARK_DIM][ARK_DIM];

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_e;

  // Flat element index for matrix element [i][j]; same packing as vec2mat.
  function automatic int unsigned elem_idx(input int unsigned i,
                                           input int unsigned j,
                                           input int unsigned dim);
    return i * dim + j;
  endfunction

endpackage

// File: rtl/add_round_key.sv
// Element-wise XOR of a state matrix with a packed round key.
// Combinational only, so it adds no latency and has no flow control.
module add_round_key
  import ark_pkg::*;
#(
  parameter int unsigned WIDTH = ARK_WIDTH,
  parameter int unsigned DIM   = ARK_DIM
) (
  input  logic [WIDTH-1:0]         mat_i [DIM][DIM],
  input  logic [DIM*DIM*WIDTH-1:0] key_i,
  output logic [DIM*DIM*WIDTH-1:0] res_o
);

  for (genvar i = 0; i < DIM; i++) begin : g_row
    for (genvar j = 0; j < DIM; j++) begin : g_col
      localparam int unsigned K = elem_idx(i, j, DIM);
      assign res_o[K*WIDTH +: WIDTH] = mat_i[i][j] ^ key_i[K*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/ark_stream_out.sv
// Captures the mixed state on the rising edge of done_i, applies the round key and streams it out bytewise.
// First byte is valid one cycle after capture; valid_o/data_o hold until ready_i accepts each byte.
module ark_stream_out
  import ark_pkg::*;
#(
  parameter int unsigned WIDTH = ARK_WIDTH,
  parameter int unsigned DIM   = ARK_DIM
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [WIDTH-1:0]         mat_i [DIM][DIM],
  input  logic                     done_i,
  input  logic [DIM*DIM*WIDTH-1:0] key_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic                     last_o,
  output logic [DIM*DIM*WIDTH-1:0] res_o,
  output logic                     res_valid_o,
  output logic                     complete_o
);

  localparam int unsigned NUM   = DIM * DIM;
  localparam int unsigned IDX_W = (NUM > 1) ? $clog2(NUM) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM - 1);

  state_e               state_q, state_d;
  logic                 done_q;
  logic                 armed_q;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [WIDTH-1:0]     buf_q [NUM];
  logic [NUM*WIDTH-1:0] xor_res;
  logic [NUM*WIDTH-1:0] buf_flat;
  logic                 capture;
  logic                 xfer;
  logic                 xfer_last;

  add_round_key #(
    .WIDTH (WIDTH),
    .DIM   (DIM)
  ) u_add_round_key (
    .mat_i (mat_i),
    .key_i (key_i),
    .res_o (xor_res)
  );

  // armed_q blocks a capture when done_i is already high coming out of reset:
  // a real rising edge needs done_i to have been sampled low first.
  assign capture   = done_i && !done_q && armed_q;
  assign xfer      = (state_q == SEND) && ready_i;
  assign xfer_last = xfer && (idx_q == LAST_IDX);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (capture)   state_d = SEND;
      SEND:    if (xfer_last) state_d = DONE;
      DONE:    if (!done_i)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    idx_d = idx_q;
    if ((state_q == IDLE && capture) || xfer_last) begin
      idx_d = '0;
    end else if (xfer) begin
      idx_d = idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      done_q  <= 1'b0;
      armed_q <= 1'b0;
      idx_q   <= '0;
      for (int k = 0; k < NUM; k++) begin
        buf_q[k] <= '0;
      end
    end else begin
      done_q <= done_i;
      if (!done_i) begin
        armed_q <= 1'b1;
      end
      idx_q <= idx_d;
      if (state_q == IDLE && capture) begin
        for (int k = 0; k < NUM; k++) begin
          buf_q[k] <= xor_res[k*WIDTH +: WIDTH];
        end
      end
    end
  end

  for (genvar k = 0; k < NUM; k++) begin : g_flat
    assign buf_flat[k*WIDTH +: WIDTH] = buf_q[k];
  end

  always_comb begin
    valid_o     = 1'b0;
    data_o      = '0;
    last_o      = 1'b0;
    complete_o  = 1'b0;
    res_valid_o = 1'b0;
    res_o       = '0;
    unique case (state_q)
      SEND: begin
        valid_o     = 1'b1;
        data_o      = buf_q[idx_q];
        last_o      = (idx_q == LAST_IDX);
        res_valid_o = 1'b1;
        res_o       = buf_flat;
      end
      DONE: begin
        complete_o  = 1'b1;
        res_valid_o = 1'b1;
        res_o       = buf_flat;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_ark_stream_out.sv
// Directed bench for ark_stream_out with a queue-based reference model checked every cycle.
module tb_ark_stream_out;
  import ark_pkg::*;

  localparam int W = 8;
  localparam int D = 4;
  localparam int N = D * D;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  matrix_t        mat;
  logic           done = 1'b0;
  logic [N*W-1:0] key = '0;
  logic [W-1:0]   data;
  logic           valid;
  logic           ready = 1'b0;
  logic           last;
  logic [N*W-1:0] res;
  logic           res_valid;
  logic           complete;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mat_v [N] = '{8'h04, 8'h66, 8'h81, 8'he5, 8'he0, 8'hcb, 8'h19, 8'h9a,
                            8'h48, 8'hf8, 8'hd3, 8'h7a, 8'h28, 8'h06, 8'h26, 8'h4c};
  logic [7:0] key_v [N] = '{8'ha0, 8'hfa, 8'hfe, 8'h17, 8'h88, 8'h54, 8'h2c, 8'hb1,
                            8'h23, 8'ha3, 8'h39, 8'h39, 8'h2a, 8'h6c, 8'h76, 8'h05};
  logic [7:0] exp_v [N] = '{8'ha4, 8'h9c, 8'h7f, 8'hf2, 8'h68, 8'h9f, 8'h35, 8'h2b,
                            8'h6b, 8'h5b, 8'hea, 8'h43, 8'h02, 8'h6a, 8'h50, 8'h49};

  ark_stream_out #(.WIDTH(W), .DIM(D)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .mat_i       (mat),
    .done_i      (done),
    .key_i       (key),
    .data_o      (data),
    .valid_o     (valid),
    .ready_i     (ready),
    .last_o      (last),
    .res_o       (res),
    .res_valid_o (res_valid),
    .complete_o  (complete)
  );

  always #5 clk = ~clk;

  // Reference model: pending bytes in a queue, plus finished / result-held flags.
  logic [7:0]     m_q [$];
  logic           m_fin = 1'b0;
  logic           m_have = 1'b0;
  logic           m_prev = 1'b0;
  logic           m_seen_low = 1'b0;
  logic [N*W-1:0] m_res = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_fin = 1'b0;
      m_have = 1'b0;
      m_prev = 1'b0;
      m_seen_low = 1'b0;
      m_res = '0;
    end else begin
      if (m_q.size() > 0) begin
        if (ready) begin
          void'(m_q.pop_front());
          if (m_q.size() == 0) m_fin = 1'b1;
        end
      end else if (m_fin) begin
        if (!done) begin
          m_fin = 1'b0;
          m_have = 1'b0;
        end
      end else if (done && !m_prev && m_seen_low) begin
        for (int i = 0; i < D; i++) begin
          for (int j = 0; j < D; j++) begin
            logic [7:0] b;
            b = mat[i][j] ^ key[(i*D+j)*W +: W];
            m_res[(i*D+j)*W +: W] = b;
            m_q.push_back(b);
          end
        end
        m_have = 1'b1;
      end
      if (!done) m_seen_low = 1'b1;
      m_prev = done;
    end
  end

  always @(negedge clk) begin
    logic           e_valid, e_last;
    logic [7:0]     e_data;
    logic [N*W-1:0] e_res;
    e_valid = (m_q.size() > 0);
    e_data  = 8'h00;
    if (e_valid) e_data = m_q[0];
    e_last  = (m_q.size() == 1);
    e_res   = m_have ? m_res : '0;
    n_tests++;
    if (valid !== e_valid || data !== e_data || last !== e_last || complete !== m_fin ||
        res_valid !== m_have || res !== e_res) begin
      n_fail++;
      $display("FAIL model_cycle t=%0t got v=%b d=%h l=%b c=%b rv=%b res=%h want v=%b d=%h l=%b c=%b rv=%b res=%h",
               $time, valid, data, last, complete, res_valid, res,
               e_valid, e_data, e_last, m_fin, m_have, e_res);
    end
  end

  logic [7:0] log_q [$];
  int         last_cnt = 0;
  logic [7:0] last_byte = 8'h00;

  always @(posedge clk) begin
    if (!rst && valid && ready) begin
      log_q.push_back(data);
      if (last) begin
        last_cnt++;
        last_byte = data;
      end
    end
  end

  task automatic check(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_q.delete();
    last_cnt = 0;
    last_byte = 8'h00;
  endtask

  task automatic wait_complete(input string name, output int cycles);
    cycles = 0;
    while (!complete && cycles < 200) begin
      step();
      cycles++;
    end
    check({name, "_complete"}, complete, 1);
  endtask

  task automatic check_stream(input string name);
    check({name, "_count"}, log_q.size(), N);
    for (int k = 0; k < N; k++) begin
      logic [7:0] got;
      got = (k < log_q.size()) ? log_q[k] : 8'hxx;
      check($sformatf("%s_byte%0d", name, k), got, exp_v[k]);
    end
    check({name, "_last_cnt"}, last_cnt, 1);
    check({name, "_last_byte"}, last_byte, 8'h49);
  endtask

  task automatic load_fips();
    for (int k = 0; k < N; k++) begin
      mat[k/D][k%D] = mat_v[k];
      key[k*W +: W] = key_v[k];
    end
  endtask

  initial begin
    int             cyc;
    logic [N*W-1:0] exp_res;
    logic [N*W-1:0] mat_flat;

    for (int k = 0; k < N; k++) begin
      exp_res[k*W +: W]  = exp_v[k];
      mat_flat[k*W +: W] = mat_v[k];
    end
    load_fips();

    // Reset state
    repeat (3) step();
    check("rst_valid", valid, 0);
    check("rst_data", data, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_complete", complete, 0);
    rst = 1'b0;
    step();
    step();
    check("post_rst_valid", valid, 0);
    check("post_rst_res", res, 0);

    // FIPS-197 round-1 vector at full throughput
    clear_log();
    ready = 1'b1;
    done = 1'b1;
    step();
    check("t1_first_valid", valid, 1);
    check("t1_first_data", data, 8'ha4);
    check("t1_res", res, exp_res);
    check("t1_res_valid", res_valid, 1);
    wait_complete("t1", cyc);
    check("t1_latency", cyc, 16);
    check("t1_valid_after", valid, 0);
    check_stream("t1");

    // Backpressure with ready pattern 1,0,0,...
    done = 1'b0;
    ready = 1'b0;
    step();
    check("t2_rearm_complete", complete, 0);
    check("t2_rearm_res_valid", res_valid, 0);
    clear_log();
    done = 1'b1;
    step();
    cyc = 0;
    while (!complete && cyc < 200) begin
      ready = (cyc % 3 == 0);
      step();
      cyc++;
    end
    check("t2_complete", complete, 1);
    check_stream("t2");

    // Perturb mat/key after 5 transfers
    done = 1'b0;
    ready = 1'b0;
    step();
    clear_log();
    done = 1'b1;
    step();
    ready = 1'b1;
    repeat (5) step();
    ready = 1'b0;
    for (int k = 0; k < N; k++) begin
      mat[k/D][k%D] = 8'hff;
      key[k*W +: W] = 8'hff;
    end
    step();
    check("t3_byte5", data, 8'h9f);
    check("t3_valid_hold", valid, 1);
    ready = 1'b1;
    wait_complete("t3", cyc);
    check_stream("t3");

    // Reset in the middle of a stream
    load_fips();
    done = 1'b0;
    ready = 1'b0;
    step();
    done = 1'b1;
    step();
    ready = 1'b1;
    repeat (7) step();
    ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("t4_rst_valid", valid, 0);
    check("t4_rst_complete", complete, 0);
    check("t4_rst_res_valid", res_valid, 0);
    step();
    rst = 1'b0;
    repeat (4) step();
    check("t4_no_capture", valid, 0);
    done = 1'b0;
    step();
    clear_log();
    done = 1'b1;
    step();
    check("t4_restart_valid", valid, 1);
    check("t4_restart_data", data, 8'ha4);
    ready = 1'b1;
    wait_complete("t4", cyc);
    check_stream("t4");

    // Re-arm with an all-zero key
    done = 1'b0;
    key = '0;
    step();
    done = 1'b1;
    step();
    check("t5_res_eq_mat", res, mat_flat);
    check("t5_first_data", data, 8'h04);
    wait_complete("t5", cyc);
    check("t5_latency", cyc, 16);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
